// File: rtl/gf2m8_mul.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// gf2m8_mul
// GF(2^8) multiplier for the Reed-Solomon decoder datapath.
// It provides a purely combinational product and a registered copy with a
// valid flag for pipelined users.
//
// Parameters:
//   POLY      : field generator polynomial. Bit 8 is always 1.
//               The default 9'h11D is x^8+x^4+x^3+x^2+1.
//
// Ports:
//   clk       : clock
//   rstn      : asynchronous active-low reset. It clears only the registered
//               path.
//   x, y      : operands in polynomial basis. Bit i is the coefficient of
//               alpha^i.
//   in_valid  : qualifies x/y for capture into z_q
//   z         : combinational product x*y mod POLY. It is not gated by
//               in_valid or rstn.
//   z_q       : registered product. It holds its value while in_valid is low.
//   out_valid : z_q holds a product captured on the previous edge
// ----------------------------------------------------------------------------
module gf2m8_mul #(
  parameter logic [8:0] POLY = 9'h11D
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       in_valid,
  output logic [7:0] z,
  output logic [7:0] z_q,
  output logic       out_valid
);

  // The multiply runs in two steps.
  // First, a carry-less multiply builds a 15-bit partial product.
  // Second, that product is reduced from the top bit down. At step k, POLY
  // is aligned so that its bit 8 sits on c[k]. The XOR therefore clears
  // c[k] and folds x^k back into the lower bits. The result is AND/XOR
  // logic only.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] c;
    c = 15'd0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        c[i+j] = c[i+j] ^ (a[i] & b[j]);
      end
    end
    for (int k = 14; k >= 8; k--) begin
      if (c[k]) begin
        c[k -: 9] = c[k -: 9] ^ POLY;
      end else begin
        c[k -: 9] = c[k -: 9];
      end
    end
    return c[7:0];
  endfunction

  logic [7:0] prod_s;
  logic [7:0] z_q_r;
  logic       out_valid_r;

  // Combinational product. The key-equation PEs consume it in the same cycle.
  always_comb begin
    prod_s = gf_mul(x, y);
  end

  assign z = prod_s;

  // Registered copy of the product. Reset discards any pending product.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      z_q_r       <= 8'h00;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      z_q_r       <= prod_s;
      out_valid_r <= 1'b1;
    end else begin
      z_q_r       <= z_q_r;
      out_valid_r <= 1'b0;
    end
  end

  assign z_q       = z_q_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_gf2m8_mul.sv
`timescale 1ns/1ps
module tb_gf2m8_mul;

  logic       clk;
  logic       rstn;
  logic [7:0] x;
  logic [7:0] y;
  logic       in_valid;
  logic [7:0] z;
  logic [7:0] z_q;
  logic       out_valid;

  int         n_tests;
  int         n_fail;
  logic [7:0] exp_q[$];

  gf2m8_mul #(.POLY(9'h11D)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .x         (x),
    .y         (y),
    .in_valid  (in_valid),
    .z         (z),
    .z_q       (z_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial shift-and-XOR reference model.
  // The shifted operand is reduced at every step.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = s[7] ? ((s << 1) ^ 8'h1D) : (s << 1);
    end
    return p;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor. Each registered product is popped and compared.
  always @(negedge clk) begin
    if (rstn === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL z_q_unexpected: got out_valid=1 z_q=%h expected no output", z_q);
      end else begin
        check8("z_q_scoreboard", z_q, exp_q.pop_front());
      end
    end
  end

  // Drive one valid transaction after a rising edge.
  // The expected registered result is queued, and z is checked directly.
  task automatic drive_valid(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
    @(posedge clk);
    #1;
    x = a;
    y = b;
    in_valid = 1'b1;
    exp_q.push_back(e);
    #1;
    check8("z_comb_directed", z, e);
  endtask

  logic [7:0] tx [11] = '{8'h01, 8'hA5, 8'h00, 8'hFF, 8'h03, 8'h02, 8'h40, 8'h02, 8'h80, 8'h02, 8'h8E};
  logic [7:0] ty [11] = '{8'hA5, 8'h01, 8'hFF, 8'h00, 8'h03, 8'h40, 8'h02, 8'h80, 8'h80, 8'h8E, 8'h02};
  logic [7:0] tz [11] = '{8'hA5, 8'hA5, 8'h00, 8'h00, 8'h05, 8'h80, 8'h80, 8'h1D, 8'h13, 8'h01, 8'h01};

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] w;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
    n_tests  = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    x        = 8'h02;
    y        = 8'h80;
    in_valid = 1'b1;

    // Reset state. z keeps tracking its inputs while reset is held.
    #12;
    check8("reset_z_q", z_q, 8'h00);
    check8("reset_out_valid", {7'd0, out_valid}, 8'h00);
    check8("reset_z_comb", z, 8'h1D);
    in_valid = 1'b0;
    #10 rstn = 1'b1;

    // Directed vectors, driven back to back through both paths.
    for (int i = 0; i < 11; i++) begin
      drive_valid(tx[i], ty[i], tz[i]);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;

    // Registered path: capture, then hold with out_valid low.
    drive_valid(8'h02, 8'h80, 8'h1D);
    @(posedge clk);
    #1 in_valid = 1'b0;
    x = 8'h80;
    y = 8'h80;
    @(negedge clk);
    check8("hold_out_valid", {7'd0, out_valid}, 8'h01);
    @(posedge clk);
    #1;
    check8("hold_out_valid_low", {7'd0, out_valid}, 8'h00);
    check8("hold_z_q", z_q, 8'h1D);

    // Reset between clock edges while a product is pending.
    drive_valid(8'h80, 8'h80, 8'h13);
    @(posedge clk);
    #1 in_valid = 1'b0;
    x = 8'h02;
    y = 8'h8E;
    #1 rstn = 1'b0;
    exp_q.delete();
    #1;
    check8("async_reset_z_q", z_q, 8'h00);
    check8("async_reset_out_valid", {7'd0, out_valid}, 8'h00);
    check8("async_reset_z_comb", z, 8'h01);
    @(negedge clk);
    rstn = 1'b1;

    // First capture after reset.
    drive_valid(8'h03, 8'h03, 8'h05);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    // Exhaustive comparison against the reference model.
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        x = i[7:0];
        y = j[7:0];
        #1;
        check8("z_exhaustive", z, ref_mul(i[7:0], j[7:0]));
      end
    end

    // Commutativity and distributivity on random triples.
    for (int i = 0; i < 64; i++) begin
      a = 8'($urandom_range(255, 0));
      b = 8'($urandom_range(255, 0));
      w = 8'($urandom_range(255, 0));
      x = a; y = b; #1 r1 = z;
      x = b; y = a; #1;
      check8("commutative", z, r1);
      x = a; y = w; #1 r2 = z;
      x = a; y = b ^ w; #1 r3 = z;
      check8("distributive", r3, r1 ^ r2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog.
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
